// File: rtl/host_stream_ctrl.sv
// Host-side frame buffer and sequencer: fills a frame from the host stream, bursts it
// into the core, then captures the core's result stream into res_* strobes.
module host_stream_ctrl #(
  parameter int LOAD_WORDS = 1024,
  parameter int RES_WORDS  = 1024,
  parameter int RD_LAT     = 1,
  parameter int AW         = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          go,
  input  logic          src_valid,
  input  logic [15:0]   src_data,
  output logic          src_ready,
  output logic [15:0]   com_data_in,
  output logic          data_write_start,
  output logic          data_write_done,
  input  logic [15:0]   com_data_out,
  input  logic          output_write_start,
  input  logic          output_write_done,
  output logic          res_valid,
  output logic [15:0]   res_data,
  output logic [AW-1:0] res_index,
  output logic          busy,
  output logic          run_done,
  output logic          short_err
);

  // hi_cnt must reach RES_WORDS+RD_LAT (its saturation value); cap_cnt must reach RES_WORDS
  localparam int HW = $clog2(RES_WORDS + RD_LAT + 1);
  localparam int CW = $clog2(RES_WORDS + 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_FILL, ST_START, ST_GAP, ST_BURST, ST_WAIT, ST_CAPTURE, ST_FIN
  } state_t;

  state_t         state_reg;
  logic [AW-1:0]  fill_cnt_reg;
  logic [AW-1:0]  rd_ptr_reg;
  logic [AW-1:0]  burst_cnt_reg;
  logic [HW-1:0]  hi_cnt_reg;
  logic [CW-1:0]  cap_cnt_reg;
  logic [15:0]    mem_rd_data;

  logic           src_ready_reg;
  logic [15:0]    com_data_in_reg;
  logic           data_write_start_reg;
  logic           data_write_done_reg;
  logic           res_valid_reg;
  logic [15:0]    res_data_reg;
  logic [AW-1:0]  res_index_reg;
  logic           busy_reg;
  logic           run_done_reg;
  logic           short_err_reg;

  logic           mem_we;
  logic [HW:0]    lat_diff;
  logic           cap_elig;
  logic [CW-1:0]  cap_cnt_next;

  logic [15:0]    buf_mem [0:2**AW-1];

  // Extra MSB of lat_diff flags "still inside the read latency" (negative offset)
  always_comb begin
    mem_we       = (state_reg == ST_FILL) && src_valid;
    lat_diff     = {1'b0, hi_cnt_reg} - (HW+1)'(RD_LAT);
    cap_elig     = output_write_start
                   && ((state_reg == ST_WAIT) || (state_reg == ST_CAPTURE))
                   && !lat_diff[HW]
                   && (lat_diff[HW-1:0] < HW'(RES_WORDS));
    cap_cnt_next = cap_cnt_reg + (cap_elig ? CW'(1) : CW'(0));
  end

  always_ff @(posedge clk) begin
    if (mem_we)
      buf_mem[fill_cnt_reg] <= src_data;
    mem_rd_data <= buf_mem[rd_ptr_reg];
  end

  // rd_ptr runs two words ahead of com_data_in: one cycle of RAM read, one of output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg            <= ST_IDLE;
      fill_cnt_reg         <= '0;
      rd_ptr_reg           <= '0;
      burst_cnt_reg        <= '0;
      hi_cnt_reg           <= '0;
      cap_cnt_reg          <= '0;
      src_ready_reg        <= 1'b0;
      com_data_in_reg      <= '0;
      data_write_start_reg <= 1'b0;
      data_write_done_reg  <= 1'b0;
      res_valid_reg        <= 1'b0;
      res_data_reg         <= '0;
      res_index_reg        <= '0;
      busy_reg             <= 1'b0;
      run_done_reg         <= 1'b0;
      short_err_reg        <= 1'b0;
    end else begin
      res_valid_reg        <= 1'b0;
      run_done_reg         <= 1'b0;
      data_write_start_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (go) begin
            state_reg     <= ST_FILL;
            fill_cnt_reg  <= '0;
            short_err_reg <= 1'b0;
            src_ready_reg <= 1'b1;
            busy_reg      <= 1'b1;
          end
        end
        ST_FILL: begin
          if (src_valid) begin
            fill_cnt_reg <= fill_cnt_reg + AW'(1);
            if (fill_cnt_reg == AW'(LOAD_WORDS - 1)) begin
              state_reg            <= ST_START;
              src_ready_reg        <= 1'b0;
              data_write_start_reg <= 1'b1;
              rd_ptr_reg           <= '0;
            end
          end
        end
        ST_START: begin
          state_reg       <= ST_GAP;
          rd_ptr_reg      <= rd_ptr_reg + AW'(1);
          com_data_in_reg <= '0;
        end
        ST_GAP: begin
          state_reg           <= ST_BURST;
          rd_ptr_reg          <= rd_ptr_reg + AW'(1);
          com_data_in_reg     <= mem_rd_data;
          burst_cnt_reg       <= '0;
          data_write_done_reg <= (LOAD_WORDS == 1);
        end
        ST_BURST: begin
          rd_ptr_reg <= rd_ptr_reg + AW'(1);
          if (burst_cnt_reg == AW'(LOAD_WORDS - 1)) begin
            state_reg           <= ST_WAIT;
            com_data_in_reg     <= '0;
            data_write_done_reg <= 1'b0;
            hi_cnt_reg          <= '0;
            cap_cnt_reg         <= '0;
          end else begin
            com_data_in_reg     <= mem_rd_data;
            burst_cnt_reg       <= burst_cnt_reg + AW'(1);
            data_write_done_reg <= (burst_cnt_reg == AW'(LOAD_WORDS - 2));
          end
        end
        ST_WAIT, ST_CAPTURE: begin
          if (output_write_start) begin
            if (hi_cnt_reg != HW'(RES_WORDS + RD_LAT))
              hi_cnt_reg <= hi_cnt_reg + HW'(1);
            if (state_reg == ST_WAIT)
              state_reg <= ST_CAPTURE;
          end
          if (cap_elig) begin
            res_valid_reg <= 1'b1;
            res_data_reg  <= com_data_out;
            res_index_reg <= AW'(lat_diff[HW-1:0]);
            cap_cnt_reg   <= cap_cnt_next;
          end
          // The word arriving alongside done is still counted toward short_err
          if (output_write_done) begin
            state_reg     <= ST_FIN;
            run_done_reg  <= 1'b1;
            short_err_reg <= (cap_cnt_next < CW'(RES_WORDS));
          end
        end
        ST_FIN: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign src_ready        = src_ready_reg;
  assign com_data_in      = com_data_in_reg;
  assign data_write_start = data_write_start_reg;
  assign data_write_done  = data_write_done_reg;
  assign res_valid        = res_valid_reg;
  assign res_data         = res_data_reg;
  assign res_index        = res_index_reg;
  assign busy             = busy_reg;
  assign run_done         = run_done_reg;
  assign short_err        = short_err_reg;

endmodule

// File: tb/tb_host_stream_ctrl.sv
// Randomized bench for host_stream_ctrl: frame fill, burst timing, result capture and
// reset/ignore behaviour against a queue-based model of the frame and result stream.
module tb_host_stream_ctrl;

  localparam int LOAD = 1024;
  localparam int RES  = 1024;
  localparam int RDL  = 1;
  localparam int AW   = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          go;
  logic          src_valid;
  logic [15:0]   src_data;
  logic          src_ready;
  logic [15:0]   com_data_in;
  logic          data_write_start;
  logic          data_write_done;
  logic [15:0]   com_data_out;
  logic          output_write_start;
  logic          output_write_done;
  logic          res_valid;
  logic [15:0]   res_data;
  logic [AW-1:0] res_index;
  logic          busy;
  logic          run_done;
  logic          short_err;

  int checks   = 0;
  int failures = 0;
  int run_no   = 0;

  logic [15:0] words [LOAD];
  int          exp_idx_q [$];
  logic [15:0] exp_dat_q [$];

  host_stream_ctrl #(.LOAD_WORDS(LOAD), .RES_WORDS(RES), .RD_LAT(RDL), .AW(AW)) dut (
    .clk(clk), .rst(rst), .go(go), .src_valid(src_valid), .src_data(src_data),
    .src_ready(src_ready), .com_data_in(com_data_in), .data_write_start(data_write_start),
    .data_write_done(data_write_done), .com_data_out(com_data_out),
    .output_write_start(output_write_start), .output_write_done(output_write_done),
    .res_valid(res_valid), .res_data(res_data), .res_index(res_index), .busy(busy),
    .run_done(run_done), .short_err(short_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    if (obs !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // vmode: 0 valid always, 1 toggling, 2 random. seqw: words 0..LOAD-1 and addr^A5A5 results.
  task automatic run_frame(input int vmode, input bit seqw, input int n_hi,
                           input bit rst_in_burst, input bit inject);
    int idx, cyc, rdy_cycles, n_exp, got, done_seen, dly, e_idx;
    bit tog, v, acc;
    logic [15:0] e_dat, cd;
    run_no++;
    for (int k = 0; k < LOAD; k++)
      words[k] = seqw ? 16'(k) : 16'($urandom);
    exp_idx_q.delete();
    exp_dat_q.delete();

    go = 1'b1;
    tick();
    go = 1'b0;
    check("fill_src_ready", 32'(src_ready), 32'(1));
    check("fill_busy", 32'(busy), 32'(1));
    check("go_clears_short_err", 32'(short_err), 32'(0));

    idx = 0; cyc = 0; rdy_cycles = 0; tog = 1'b1;
    while (idx < LOAD && cyc < 20000) begin
      if (src_ready) rdy_cycles++;
      case (vmode)
        0:       v = 1'b1;
        1:       begin v = tog; tog = ~tog; end
        default: v = 1'($urandom_range(0, 1));
      endcase
      src_valid          = v;
      src_data           = v ? words[idx] : 16'($urandom);
      output_write_start = inject && (cyc == 5);
      output_write_done  = inject && (cyc == 5);
      acc = v && src_ready;
      tick();
      cyc++;
      if (acc) idx++;
    end
    src_valid = 1'b0;
    output_write_start = 1'b0;
    output_write_done  = 1'b0;
    if (idx < LOAD) begin
      check("fill_timeout", 32'(idx), 32'(LOAD));
      return;
    end
    if (vmode == 0) check("src_ready_cycles", 32'(rdy_cycles), 32'(LOAD));

    // cycle T0
    check("t0_start", 32'(data_write_start), 32'(1));
    check("t0_src_ready", 32'(src_ready), 32'(0));
    check("t0_data", 32'(com_data_in), 32'(0));
    for (int t = 1; t <= LOAD + 1; t++) begin
      tick();
      check("burst_start_low", 32'(data_write_start), 32'(0));
      if (t == 1) begin
        check("gap_data", 32'(com_data_in), 32'(0));
        check("gap_done", 32'(data_write_done), 32'(0));
      end else begin
        check("burst_data", 32'(com_data_in), 32'(words[t-2]));
        check("burst_done", 32'(data_write_done), 32'((t - 2) == LOAD - 1));
      end
      go = inject && (t == 100);
      if (rst_in_burst && t == LOAD + 1) begin
        #1 rst = 1'b1;
        #1;
        check("rst_done_low", 32'(data_write_done), 32'(0));
        check("rst_start_low", 32'(data_write_start), 32'(0));
        check("rst_data_zero", 32'(com_data_in), 32'(0));
        check("rst_busy_low", 32'(busy), 32'(0));
        tick();
        rst = 1'b0;
        tick();
        check("rst_idle_busy", 32'(busy), 32'(0));
        $display("run %0d: reset during last burst word, dut back in idle", run_no);
        return;
      end
    end
    go = 1'b0;
    tick();
    check("post_burst_data", 32'(com_data_in), 32'(0));
    check("post_burst_done", 32'(data_write_done), 32'(0));
    check("wait_busy", 32'(busy), 32'(1));

    dly = $urandom_range(0, 4);
    for (int i = 0; i < dly; i++) tick();

    n_exp = n_hi - RDL;
    if (n_exp < 0) n_exp = 0;
    if (n_exp > RES) n_exp = RES;
    got = 0; done_seen = 0;
    for (int j = 0; j < n_hi + 6; j++) begin
      if (res_valid) begin
        got++;
        if (exp_idx_q.size() == 0) begin
          check("res_extra", 32'(got), 32'(n_exp));
        end else begin
          e_idx = exp_idx_q.pop_front();
          e_dat = exp_dat_q.pop_front();
          check("res_index", 32'(res_index), 32'(e_idx));
          check("res_data", 32'(res_data), 32'(e_dat));
        end
      end
      if (run_done) begin
        done_seen++;
        check("short_err", 32'(short_err), 32'(n_exp < RES));
      end
      if (j < n_hi) begin
        cd = seqw ? (16'(j - RDL) ^ 16'hA5A5) : 16'($urandom);
        output_write_start = 1'b1;
        output_write_done  = (j == n_hi - 1);
        com_data_out       = cd;
        if (j >= RDL && j - RDL < RES) begin
          exp_idx_q.push_back(j - RDL);
          exp_dat_q.push_back(cd);
        end
      end else begin
        output_write_start = 1'b0;
        output_write_done  = 1'b0;
        com_data_out       = 16'($urandom);
      end
      tick();
    end
    check("res_count", 32'(got), 32'(n_exp));
    check("run_done_pulses", 32'(done_seen), 32'(1));
    check("idle_busy", 32'(busy), 32'(0));
    $display("run %0d: vmode=%0d n_hi=%0d inject=%0d results=%0d expected=%0d short_err=%0d",
             run_no, vmode, n_hi, inject, got, n_exp, short_err);
  endtask

  initial begin
    rst = 1'b1; go = 1'b0; src_valid = 1'b0; src_data = '0;
    com_data_out = '0; output_write_start = 1'b0; output_write_done = 1'b0;
    tick();
    tick();
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_src_ready", 32'(src_ready), 32'(0));
    check("reset_data", 32'(com_data_in), 32'(0));
    check("reset_strobes", 32'({data_write_start, data_write_done, res_valid, run_done}), 32'(0));
    check("reset_short_err", 32'(short_err), 32'(0));
    rst = 1'b0;
    tick();

    run_frame(0, 1'b1, 1025, 1'b0, 1'b0);
    run_frame(1, 1'b1, 500,  1'b0, 1'b0);
    tick();
    tick();
    check("short_err_sticky", 32'(short_err), 32'(1));
    run_frame(2, 1'b0, 1030, 1'b0, 1'b0);
    run_frame(0, 1'b0, 1025, 1'b1, 1'b0);
    run_frame(0, 1'b1, 1025, 1'b0, 1'b0);
    run_frame(2, 1'b0, 1025, 1'b0, 1'b1);
    run_frame(0, 1'b0, 1,    1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
